// File: rtl/alu_control_word_executor.sv
// Control-word executor: owns the 16x16 register file and per-register flags,
// runs each control word through IDLE -> EXEC (ALU req/ack) -> WB.
module alu_control_word_executor #(
    parameter int ALU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [54:0] cw,
    input  logic        cw_valid,
    output logic        cw_ready,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_req,
    input  logic        alu_ack,
    input  logic [15:0] alu_result,
    input  logic        alu_ovf,
    input  logic        alu_err,
    input  logic [15:0] mem_rdata,
    output logic [15:0] store_data,
    output logic        mem_store,
    output logic        stk_store,
    output logic        pc_advance,
    output logic [15:0] zeroflag,
    output logic [15:0] signflag,
    output logic [15:0] overflow,
    output logic [15:0] errorbit
);

    localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam bit TO_EN = (ALU_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ALU_TIMEOUT > 0) ? ALU_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic              pc_inc_r;
    logic [3:0]        op_r;
    logic [3:0]        os_r;
    logic [1:0]        ls_r;
    logic              store_mem_r;
    logic              store_stk_r;
    logic [15:0]       opa_r;
    logic [15:0]       opb_r;
    logic [15:0]       res_r;
    logic              ovf_r;
    logic              err_r;
    logic              timeout_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              timeout_hit_s;

    logic              cw_ready_r;
    logic              alu_req_r;
    logic              mem_store_r;
    logic              stk_store_r;
    logic              pc_advance_r;
    logic              ready_s;
    logic              req_s;
    logic              wb_enter_s;
    logic              mem_store_s;
    logic              stk_store_s;
    logic              pc_advance_s;

    logic [15:0]       regs_r [16];
    logic [15:0]       zeroflag_r;
    logic [15:0]       signflag_r;
    logic [15:0]       overflow_r;
    logic [15:0]       errorbit_r;

    logic              wr_en_s;
    logic [15:0]       wr_data_s;
    logic              wr_ovf_s;
    logic              wr_err_s;
    logic              err_only_s;

    function automatic logic [15:0] pick_operand(input logic src,
                                                 input logic [15:0] altern,
                                                 input logic [15:0] reg_val);
        return src ? altern : reg_val;
    endfunction

    assign timeout_hit_s = TO_EN && (cnt_r == TO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cw_valid) state_s = S_EXEC;
                else          state_s = S_IDLE;
            end
            S_EXEC: begin
                if (alu_ack)            state_s = S_WB;
                else if (timeout_hit_s) state_s = S_WB;
                else                    state_s = S_EXEC;
            end
            S_WB:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode; a timed-out EXEC enters WB without ack, which suppresses stores
    always_comb begin
        wb_enter_s   = (state_r == S_EXEC) && (state_s == S_WB);
        ready_s      = (state_s == S_IDLE);
        req_s        = (state_s == S_EXEC);
        mem_store_s  = wb_enter_s && alu_ack && store_mem_r;
        stk_store_s  = wb_enter_s && alu_ack && store_stk_r;
        pc_advance_s = wb_enter_s && pc_inc_r;
    end

    // Registered handshake and strobe outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_ready_r   <= 1'b1;
            alu_req_r    <= 1'b0;
            mem_store_r  <= 1'b0;
            stk_store_r  <= 1'b0;
            pc_advance_r <= 1'b0;
        end else begin
            cw_ready_r   <= ready_s;
            alu_req_r    <= req_s;
            mem_store_r  <= mem_store_s;
            stk_store_r  <= stk_store_s;
            pc_advance_r <= pc_advance_s;
        end
    end

    // Control-word latch, operand fetch, ALU capture and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_inc_r    <= 1'b0;
            op_r        <= 4'd0;
            os_r        <= 4'd0;
            ls_r        <= 2'd0;
            store_mem_r <= 1'b0;
            store_stk_r <= 1'b0;
            opa_r       <= 16'd0;
            opb_r       <= 16'd0;
            res_r       <= 16'd0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            timeout_r   <= 1'b0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cw_valid) begin
                        pc_inc_r    <= cw[54];
                        op_r        <= cw[53:50];
                        opa_r       <= pick_operand(cw[9], cw[49:34], regs_r[cw[17:14]]);
                        opb_r       <= pick_operand(cw[8], cw[33:18], regs_r[cw[13:10]]);
                        os_r        <= cw[7:4];
                        ls_r        <= cw[3:2];
                        store_mem_r <= cw[1];
                        store_stk_r <= cw[0];
                        timeout_r   <= 1'b0;
                        cnt_r       <= '0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_EXEC: begin
                    if (alu_ack) begin
                        res_r <= alu_result;
                        ovf_r <= alu_ovf;
                        err_r <= alu_err;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (timeout_hit_s) timeout_r <= 1'b1;
                        else               timeout_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Write-back decode; timeout takes priority over load_src
    always_comb begin
        wr_en_s    = 1'b0;
        wr_data_s  = 16'd0;
        wr_ovf_s   = 1'b0;
        wr_err_s   = 1'b0;
        err_only_s = 1'b0;
        if (state_r == S_WB) begin
            if (timeout_r) begin
                err_only_s = 1'b1;
            end else begin
                case (ls_r)
                    2'b01: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = res_r;
                        wr_ovf_s  = ovf_r;
                        wr_err_s  = err_r;
                    end
                    2'b10: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = mem_rdata;
                    end
                    2'b11:   err_only_s = 1'b1;
                    default: err_only_s = 1'b0;
                endcase
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register file and per-register flags, committed at the end of WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_r[i] <= 16'd0;
            zeroflag_r <= 16'hFFFF;
            signflag_r <= 16'h0000;
            overflow_r <= 16'h0000;
            errorbit_r <= 16'h0000;
        end else if (wr_en_s) begin
            regs_r[os_r]     <= wr_data_s;
            zeroflag_r[os_r] <= (wr_data_s == 16'd0);
            signflag_r[os_r] <= wr_data_s[15];
            overflow_r[os_r] <= wr_ovf_s;
            errorbit_r[os_r] <= wr_err_s;
        end else if (err_only_s) begin
            errorbit_r[os_r] <= 1'b1;
        end else begin
            errorbit_r <= errorbit_r;
        end
    end

    assign cw_ready   = cw_ready_r;
    assign alu_req    = alu_req_r;
    assign alu_op     = op_r;
    assign alu_a      = opa_r;
    assign alu_b      = opb_r;
    assign store_data = res_r;
    assign mem_store  = mem_store_r;
    assign stk_store  = stk_store_r;
    assign pc_advance = pc_advance_r;
    assign zeroflag   = zeroflag_r;
    assign signflag   = signflag_r;
    assign overflow   = overflow_r;
    assign errorbit   = errorbit_r;

endmodule

// File: doc/alu_control_word_executor.md
Name: alu_control_word_executor

Overview:
Consumes the 55-bit control words produced by the instruction decoders and executes them. It owns the 16x16-bit register file and the per-register flag vectors zeroflag/signflag/overflow/errorbit that the decoders read. It fetches operands, drives the ALU through a req/ack handshake, writes back the result, updates the flags, and pulses the PC-advance and store strobes.

Parameters:
ALU_TIMEOUT, 64, max EXEC cycles waiting for alu_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cw  in  55  control word; bits 54..0: [54] pc_inc, [53:50] alu_op, [49:34] a_altern, [33:18] b_altern, [17:14] a_select, [13:10] b_select, [9] a_source, [8] b_source, [7:4] out_select, [3:2] load_src, [1] store_mem, [0] store_stk
cw_valid  in  1  cw present
cw_ready  out  1  executor accepts cw this cycle
alu_op  out  4  ALU opcode
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_req  out  1  ALU request
alu_ack  in  1  ALU result valid
alu_result  in  16  ALU result
alu_ovf  in  1  ALU overflow
alu_err  in  1  ALU error
mem_rdata  in  16  write-back data when load_src=10
store_data  out  16  data for memory/stack store
mem_store  out  1  one-cycle memory store strobe
stk_store  out  1  one-cycle stack store strobe
pc_advance  out  1  one-cycle PC increment strobe
zeroflag  out  16  bit i: reg[i]==0
signflag  out  16  bit i: reg[i][15]
overflow  out  16  bit i: last ALU overflow written to reg i
errorbit  out  16  bit i: last error written to reg i

Behaviour:
- Reset (async, immediate): state IDLE; all regs 0; zeroflag=16'hFFFF; signflag/overflow/errorbit=0; alu_req, mem_store, stk_store, pc_advance, store_data, alu_op/a/b = 0; timeout counter 0.
- FSM IDLE -> EXEC -> WB -> IDLE.
- IDLE: cw_ready=1. On cw_valid, at the clock edge:
  - latch cw;
  - latch A = a_source ? a_altern : reg[a_select];
  - latch B = b_source ? b_altern : reg[b_select];
  - clear counter; go EXEC.
  - Select/altern fields not used by the chosen source are don't-care; source bits must be known.
- EXEC: cw_ready=0; alu_req=1; alu_op/alu_a/alu_b held stable from latched values.
  - alu_ack=1: capture alu_result/ovf/err; go WB. Ack in the first EXEC cycle is legal.
  - Else counter++. If ALU_TIMEOUT!=0 and counter reaches ALU_TIMEOUT: go WB with timeout flag set.
- WB (exactly one cycle, cw_ready=0, alu_req=0), actions by load_src:
  - 01: reg[out_select] = captured result; overflow[os] = alu_ovf; errorbit[os] = alu_err.
  - 10: reg[os] = mem_rdata sampled this cycle; overflow[os] = 0; errorbit[os] = 0.
  - 00: no write; flags unchanged.
  - 11 (illegal): no write; errorbit[os] = 1.
  - On any write: zeroflag[os] = (value==0); signflag[os] = value[15].
  - Timeout overrides load_src: no write; errorbit[os] = 1; mem_store/stk_store suppressed; pc_advance still follows pc_inc.
  - mem_store = store_mem, stk_store = store_stk; store_data = captured ALU result. Both strobes may pulse together.
  - pc_advance = pc_inc.
  - Strobes are registered, high only during the WB cycle.
- Minimum throughput is 3 cycles per control word. WB commits before the next IDLE read, so there is no read-after-write hazard and no bypass is needed.
- cw_valid is ignored while cw_ready=0; the upstream stage holds cw until accepted.
- Flag outputs are registered and change only in WB or reset.
- Reset mid-EXEC/WB: the instruction is abandoned; no write or strobe occurs.

Test Plan:
- Reset pulse -> zeroflag=FFFF, signflag=overflow=errorbit=0, cw_ready=1, alu_req=0, all strobes 0.
- Constant load: cw with a_source=1, a_altern=3C00, alu_op=0, out_select=3, load_src=01, pc_inc=1; model acks 2 cycles after req with result=A -> reg3=3C00, zeroflag[3]=0, signflag[3]=0, one pc_advance pulse, cw_ready low 4 cycles.
- Negate: reg5=0005; cw a_source=1 a_altern=0, b_source=0 b_select=5, alu_op=2, out_select=5; model returns FFFB, ovf=0 -> alu_b observed 0005, reg5=FFFB, signflag[5]=1, zeroflag[5]=0.
- Timeout, ALU_TIMEOUT=4, ack never asserted -> alu_req high exactly 4 cycles; errorbit[out_select]=1; register unchanged; no store strobe.
- Store only: load_src=00, store_mem=1, result 1234 -> single mem_store pulse with store_data=1234; no register or flag change; back-to-back cw accepted at 3-cycle spacing with ack in the first EXEC cycle.
- Async reset asserted mid-EXEC -> alu_req falls without waiting for clk; registers cleared; no WB strobes after release.
